axis_tone_sequencer: RTL
========================

# axis_tone_sequencer

- Programmable step-frequency controller for the NCO → error-feedback-modulator DAC chain.
- Stores a short program of (phase step, dwell) entries, loaded over an AXI-stream config port.
- On `start`, plays the entries out on an AXI-stream step port that feeds the NCO's step input, holding each step for its dwell count. Supports one-shot or looping playback.
- Lets the bench or host produce multi-tone sweeps without cycle-counting in the testbench.

## Interface
- `ACC_WIDTH`, 32, NCO phase-accumulator/step width (8 integer + 24 fraction bits).
- `DWELL_WIDTH`, 24, dwell count width, in accepted step-port cycles.
- `DEPTH`, 8, program table entries (power of two, ≥2).
- `aclk` in 1: single clock.
- `arst` in 1: reset, synchronous, active-high.
- `s_axis_cfg_tdata` in ACC_WIDTH+DWELL_WIDTH: `{dwell, step}`, with step in the LSBs.
- `s_axis_cfg_tvalid` in 1: config beat valid.
- `s_axis_cfg_tlast` in 1: last entry of the program.
- `s_axis_cfg_tready` out 1: config accept; high only in IDLE.
- `start` in 1: one-cycle pulse that begins playback.
- `stop` in 1: one-cycle pulse that aborts playback.
- `loop_en` in 1: wrap to entry 0 after the last entry instead of finishing.
- `m_axis_step_tdata` out ACC_WIDTH: step value to the NCO.
- `m_axis_step_tvalid` out 1: step valid; this is the NCO step enable.
- `m_axis_step_tready` in 1: NCO accept.
- `busy` out 1: high while not IDLE.
- `done` out 1: one-cycle pulse when a program completes normally.
- `entry_idx` out $clog2(DEPTH): index of the entry currently presented.

## Operation
- States: IDLE, RUN, and MUTE (MUTE only when the macro is enabled).
- Reset values: state IDLE; `n_entries`=0; `wr_ptr`=0; all outputs 0. Table RAM contents are not cleared.
- Config writes (IDLE only):
  - Each beat with `tvalid&tready` writes `table[wr_ptr]` and increments `wr_ptr`.
  - `tlast` sets `n_entries`=`wr_ptr`+1 and resets `wr_ptr` to 0.
  - When `wr_ptr` reaches DEPTH-1 without `tlast`, that beat completes the program: `n_entries`=DEPTH and `wr_ptr` wraps to 0.
  - A new program overwrites the old one from entry 0.
- `start` in IDLE with `n_entries`≠0 → RUN. `idx`=0 and the dwell counter loads `dwell[0]`. A dwell of 0 is treated as 1.
- `start` in IDLE with `n_entries`=0 → ignored. `start` in RUN → ignored.
- In RUN, `tvalid`=1 and `tdata`=`step[idx]`. The dwell counter decrements only on cycles where `tvalid&tready`.
- When the entry's dwell is exhausted, the next cycle presents `idx`+1.
- After the last entry (`idx`=`n_entries`-1):
  - `loop_en`=1 → `idx`=0 and playback continues.
  - `loop_en`=0 → IDLE, `tvalid`=0, `done`=1 for one cycle.
- `loop_en` is sampled at each wrap decision, not only at start.
- `stop` in RUN → IDLE on the next cycle. `done` is not pulsed.
- `start` and `stop` asserted together → `stop` wins.
- `tdata` holds its last value while `tvalid`=0.
- `arst` mid-RUN: everything returns to reset values next cycle. `n_entries`=0, so the program must be reloaded.

## Timing
- `start` sampled at edge T → `tvalid`=1 and `tdata`=`step[0]` from T+1.
- With `tready` held high, entry k is presented for exactly max(`dwell[k]`,1) consecutive cycles.
- `tready` low freezes the dwell count; it does not extend or skip any entry.
- `done` (and `tvalid`=0) appears in the first cycle after the last entry's final accepted cycle.
- `busy` equals (state≠IDLE) and is registered.
- `s_axis_cfg_tready` = (state==IDLE)&&!`arst`.
- `entry_idx` changes in the same cycle as `tdata`.

## Configuration
- `TONE_SEQ_MUTE_EN` defined:
  - On normal completion or on `stop`, the block enters MUTE and presents `tdata`=0 with `tvalid`=1 until that beat is accepted.
  - It then goes to IDLE. `done` is pulsed on the IDLE entry cycle, on normal completion only.
  - `busy` stays high during MUTE.
- `TONE_SEQ_MUTE_EN` undefined:
  - MUTE does not exist; the block goes directly to IDLE.
  - The NCO keeps its last step.

## Test plan
- Load 3 entries {step=85900,d=4},{343600,2},{171800,3} with `tlast` on beat 3, `tready`=1, pulse `start` → `tdata` is 85900×4, 343600×2, 171800×3 (9 cycles); `done` on cycle 10; `tvalid`=0 after.
- Same program, `loop_en`=1 → sequence repeats; `stop` after 20 cycles → IDLE next cycle, no `done`; with the macro, exactly one `tdata`=0 beat first.
- Entry with d=0 → presented 1 cycle. Hold `tready` low 5 cycles mid-entry → that entry lasts dwell+5 cycles.
- 8 beats without `tlast` → `n_entries`=8, `wr_ptr` wraps. `start` with an empty program after reset → `busy` stays 0.
- `start` and `stop` in the same cycle → remains IDLE. `start` during RUN → no restart (`entry_idx` unchanged).
- `arst` mid-RUN → all outputs 0 next cycle; a later `start` is ignored until a reload.

Source files
------------

// File: rtl/axis_tone_sequencer.sv
// axis_tone_sequencer: plays a loaded (step, dwell) program out to an NCO step port
//   Build option: TONE_SEQ_MUTE_EN adds a MUTE state that sends one zero step before idling.
//   Ports: aclk, arst (sync, active-high); s_axis_cfg_* loads {dwell, step} entries;
//   start/stop/loop_en control playback; m_axis_step_* feeds the NCO step input;
//   busy/done/entry_idx report status.
module axis_tone_sequencer #(
    parameter int ACC_WIDTH   = 32,
    parameter int DWELL_WIDTH = 24,
    parameter int DEPTH       = 8
) (
    input  logic                             aclk,
    input  logic                             arst,
    input  logic [ACC_WIDTH+DWELL_WIDTH-1:0] s_axis_cfg_tdata,
    input  logic                             s_axis_cfg_tvalid,
    input  logic                             s_axis_cfg_tlast,
    output logic                             s_axis_cfg_tready,
    input  logic                             start,
    input  logic                             stop,
    input  logic                             loop_en,
    output logic [ACC_WIDTH-1:0]             m_axis_step_tdata,
    output logic                             m_axis_step_tvalid,
    input  logic                             m_axis_step_tready,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(DEPTH)-1:0]         entry_idx
);
    localparam int IW = $clog2(DEPTH);
    localparam int TW = ACC_WIDTH + DWELL_WIDTH;
`ifdef TONE_SEQ_MUTE_EN
    typedef enum logic [1:0] {IDLE, RUN, MUTE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif
    state_t                 state, state_n;
    logic [TW-1:0]          tbl [DEPTH];
    logic [TW-1:0]          rd;
    logic [IW-1:0]          wr_ptr, wr_ptr_n, idx, idx_n, nidx;
    logic [IW:0]            n_ent, n_ent_n;
    logic [DWELL_WIDTH-1:0] cnt, cnt_n, ld;
    logic [ACC_WIDTH-1:0]   tdata_n;
    logic                   tvalid_n, done_n, cfg_we, cfg_end, last, exhaust;
`ifdef TONE_SEQ_MUTE_EN
    logic                   mute_done, mute_done_n;
`endif
    assign s_axis_cfg_tready = (state == IDLE) && !arst;
    assign cfg_we            = s_axis_cfg_tvalid && s_axis_cfg_tready;
    assign cfg_end           = s_axis_cfg_tlast || (wr_ptr == IW'(DEPTH - 1));
    assign busy              = state != IDLE;
    assign entry_idx         = idx;
    assign last              = {1'b0, idx} == n_ent - 1'b1;
    assign nidx              = last ? IW'(0) : idx + 1'b1;
    // In IDLE the next entry is always 0; in RUN it is the successor (wrapping after the last).
    assign rd                = tbl[(state == IDLE) ? IW'(0) : nidx];
    assign ld                = (rd[TW-1 -: DWELL_WIDTH] == '0) ? DWELL_WIDTH'(1) : rd[TW-1 -: DWELL_WIDTH];
    assign exhaust           = m_axis_step_tready && (cnt == DWELL_WIDTH'(1));
    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        n_ent_n  = n_ent;
        idx_n    = idx;
        cnt_n    = cnt;
        tdata_n  = m_axis_step_tdata;
        tvalid_n = m_axis_step_tvalid;
        done_n   = 1'b0;
`ifdef TONE_SEQ_MUTE_EN
        mute_done_n = mute_done;
`endif
        if (cfg_we) begin
            wr_ptr_n = cfg_end ? IW'(0) : wr_ptr + 1'b1;
            n_ent_n  = cfg_end ? {1'b0, wr_ptr} + 1'b1 : n_ent;
        end
        case (state)
            IDLE: if (start && !stop && n_ent != '0) begin
                state_n  = RUN;
                idx_n    = '0;
                cnt_n    = ld;
                tdata_n  = rd[ACC_WIDTH-1:0];
                tvalid_n = 1'b1;
            end
            RUN: if (stop || (exhaust && last && !loop_en)) begin
`ifdef TONE_SEQ_MUTE_EN
                state_n     = MUTE;
                tdata_n     = '0;
                tvalid_n    = 1'b1;
                mute_done_n = !stop;
`else
                state_n  = IDLE;
                tvalid_n = 1'b0;
                done_n   = !stop;
`endif
            end else if (m_axis_step_tready) begin
                idx_n   = exhaust ? nidx : idx;
                cnt_n   = exhaust ? ld : cnt - 1'b1;
                tdata_n = exhaust ? rd[ACC_WIDTH-1:0] : m_axis_step_tdata;
            end
`ifdef TONE_SEQ_MUTE_EN
            MUTE: if (m_axis_step_tready) begin
                state_n  = IDLE;
                tvalid_n = 1'b0;
                done_n   = mute_done;
            end
`endif
            default: ;
        endcase
    end
    always_ff @(posedge aclk) begin
        if (arst) begin
            state              <= IDLE;
            wr_ptr             <= '0;
            n_ent              <= '0;
            idx                <= '0;
            cnt                <= '0;
            m_axis_step_tdata  <= '0;
            m_axis_step_tvalid <= 1'b0;
            done               <= 1'b0;
`ifdef TONE_SEQ_MUTE_EN
            mute_done          <= 1'b0;
`endif
        end else begin
            state              <= state_n;
            wr_ptr             <= wr_ptr_n;
            n_ent              <= n_ent_n;
            idx                <= idx_n;
            cnt                <= cnt_n;
            m_axis_step_tdata  <= tdata_n;
            m_axis_step_tvalid <= tvalid_n;
            done               <= done_n;
`ifdef TONE_SEQ_MUTE_EN
            mute_done          <= mute_done_n;
`endif
        end
    end
    always_ff @(posedge aclk) begin
        if (cfg_we) tbl[wr_ptr] <= s_axis_cfg_tdata;
    end
endmodule
